// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between the fetch and data requesters.
// Optional macro SRAM_ARB_RDATA_HOLD_EN adds per-port read-data holding registers.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Handshake: a requester holds req/addr/we/wdata stable until it sees its gnt;
  // the transfer happens in the cycle where req and gnt are both high.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t     owner_q, owner_d;
  logic [3:0] starve_cnt;

  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      if (inst_req && data_req) begin
        inst_gnt = (starve_cnt >= STARVE_LIM);
        data_gnt = !(starve_cnt >= STARVE_LIM);
      end else begin
        inst_gnt = inst_req;
        data_gnt = data_req;
      end
    end
  end

  // Counts consecutive cycles a waiting fetch lost to data.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= 4'd0;
    end else if (data_gnt && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_en    = inst_gnt | data_gnt;
    mem_we    = data_gnt ? data_we : {BE_W{1'b0}};
    mem_addr  = data_gnt ? data_addr : inst_addr;
    mem_wdata = data_wdata;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (inst_gnt) begin
      owner_d = OWN_INST;
    end else if (data_gnt && (data_we == {BE_W{1'b0}})) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Gating with reset drops the response of a read granted just before reset.
  assign inst_rvalid = (owner_q == OWN_INST) && !reset;
  assign data_rvalid = (owner_q == OWN_DATA) && !reset;

`ifdef SRAM_ARB_RDATA_HOLD_EN
  logic [DATA_W-1:0] inst_hold, data_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_hold <= '0;
      data_hold <= '0;
    end else begin
      if (inst_rvalid) inst_hold <= mem_rdata;
      if (data_rvalid) data_hold <= mem_rdata;
    end
  end

  assign inst_rdata = inst_rvalid ? mem_rdata : inst_hold;
  assign data_rdata = data_rvalid ? mem_rdata : data_hold;
`else
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a
// transaction-level reference (request rules, shadow memory, response queue).
module tb_sram_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BW         = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  logic              clk, reset;
  logic              inst_req, inst_gnt, inst_rvalid;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_gnt, data_rvalid;
  logic [BW-1:0]     data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              mem_en;
  logic [BW-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model (256 words, indexed by addr[9:2]) ----------------
  logic [DATA_W-1:0] sram [0:255];
  logic              pl_clr, pl_en;
  logic [7:0]        pl_idx;
  logic [DATA_W-1:0] pl_val;

  function automatic logic [DATA_W-1:0] merge(logic [DATA_W-1:0] old_w,
                                              logic [DATA_W-1:0] new_w,
                                              logic [BW-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else begin
      if (pl_en) sram[pl_idx] <= pl_val;
      if (mem_en) begin
        if (mem_we != '0) sram[mem_addr[9:2]] <= merge(sram[mem_addr[9:2]], mem_wdata, mem_we);
        else              mem_rdata <= sram[mem_addr[9:2]];
      end
    end
  end

  // ---------------- scoreboard / reference ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                port_q[$];
  logic [DATA_W-1:0] ref_mem [0:255];
  int                lost_streak = 0;
  logic [DATA_W-1:0] hold_i = '0, hold_d = '0;
  logic              m_ig, m_dg;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic eval_cycle();
    logic              e_ig, e_dg, e_irv, e_drv;
    logic [DATA_W-1:0] e_rd;
    int                port;
    e_irv = 1'b0; e_drv = 1'b0; e_rd = '0; port = 0;
    if (reset) begin
      exp_q.delete();
      port_q.delete();
    end else if (exp_q.size() > 0) begin
      e_rd  = exp_q.pop_front();
      port  = port_q.pop_front();
      e_irv = (port == 1);
      e_drv = (port == 2);
    end
    if (reset) begin
      e_ig = 1'b0; e_dg = 1'b0;
    end else if (inst_req && data_req) begin
      e_ig = (lost_streak >= STARVE_MAX);
      e_dg = !e_ig;
    end else begin
      e_ig = inst_req; e_dg = data_req;
    end

    check_eq("inst_gnt", inst_gnt, e_ig);
    check_eq("data_gnt", data_gnt, e_dg);
    check_eq("mem_en", mem_en, e_ig | e_dg);
    check_eq("mem_we", mem_we, e_dg ? data_we : '0);
    if (e_ig || e_dg) check_eq("mem_addr", mem_addr, e_dg ? data_addr : inst_addr);
    if (e_dg && data_we != '0) check_eq("mem_wdata", mem_wdata, data_wdata);
    check_eq("inst_rvalid", inst_rvalid, e_irv);
    check_eq("data_rvalid", data_rvalid, e_drv);
`ifdef SRAM_ARB_RDATA_HOLD_EN
    if (!reset) begin
      check_eq("inst_rdata", inst_rdata, e_irv ? e_rd : hold_i);
      check_eq("data_rdata", data_rdata, e_drv ? e_rd : hold_d);
    end
`else
    if (e_irv) check_eq("inst_rdata", inst_rdata, e_rd);
    if (e_drv) check_eq("data_rdata", data_rdata, e_rd);
`endif

    if (e_ig) begin
      exp_q.push_back(ref_mem[inst_addr[9:2]]);
      port_q.push_back(1);
    end
    if (e_dg) begin
      if (data_we == '0) begin
        exp_q.push_back(ref_mem[data_addr[9:2]]);
        port_q.push_back(2);
      end else begin
        ref_mem[data_addr[9:2]] = merge(ref_mem[data_addr[9:2]], data_wdata, data_we);
      end
    end
    if (e_irv) hold_i = e_rd;
    if (e_drv) hold_d = e_rd;
    if (reset) begin
      hold_i = '0; hold_d = '0;
    end
    if (reset || !inst_req || e_ig) lost_streak = 0;
    else if (e_dg && lost_streak < STARVE_MAX) lost_streak++;
    m_ig = e_ig;
    m_dg = e_dg;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle(int n);
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic preload(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] v);
    inst_req = 1'b0; data_req = 1'b0;
    pl_en = 1'b1; pl_idx = a[9:2]; pl_val = v;
    ref_mem[a[9:2]] = v;
    step();
    pl_en = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    return {10'($urandom_range(0, 3)), 12'd0, 8'($urandom_range(0, 31)), 2'b00};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    reset = 1'b1; pl_clr = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    data_req = 1'b1; data_we = '0; data_addr = 32'h0000_0080; data_wdata = '0;

    // reset with both requests high
    sample();
    check_eq("rst_mem_en", mem_en, 1'b0);
    advance();
    pl_clr = 1'b0;
    step();
    reset = 1'b0;
    sample();
    check_eq("rel_data_gnt", data_gnt, 1'b1);
    check_eq("rel_inst_gnt", inst_gnt, 1'b0);
    advance();
    idle(2);

    // single fetch
    preload(32'h1c00_0000, 32'h0280_0c0c);
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    sample();
    check_eq("fetch_gnt", inst_gnt, 1'b1);
    check_eq("fetch_mem_addr", mem_addr, 32'h1c00_0000);
    advance();
    inst_req = 1'b0;
    sample();
    check_eq("fetch_rvalid", inst_rvalid, 1'b1);
    check_eq("fetch_rdata", inst_rdata, 32'h0280_0c0c);
    check_eq("fetch_drvalid", data_rvalid, 1'b0);
    advance();

    // partial write then read-back
    preload(32'h0000_0100, 32'h1122_3344);
    data_req = 1'b1; data_we = 4'b0011; data_addr = 32'h0000_0100; data_wdata = 32'hAABB_CCDD;
    step();
    data_we = 4'b0000;
    sample();
    check_eq("wr_no_rvalid", data_rvalid, 1'b0);
    advance();
    data_req = 1'b0;
    sample();
    check_eq("rd_after_wr", data_rdata, 32'h1122_CCDD);
    advance();
    idle(1);

    // contention: expect D,D,D,D,I repeating
    inst_req = 1'b1; inst_addr = 32'h0000_0010;
    data_req = 1'b1; data_we = '0; data_addr = 32'h0000_0020;
    for (int k = 0; k < 12; k++) begin
      sample();
      check_eq("contend_inst_gnt", inst_gnt, (k % 5) == 4);
      check_eq("contend_inst_rvalid", inst_rvalid, (k > 0) && ((k % 5) == 0));
      advance();
    end
    idle(2);

    // reset in the cycle after a data read grant
    data_req = 1'b1; data_we = '0; data_addr = 32'h0000_0100;
    step();
    data_req = 1'b0; reset = 1'b1;
    sample();
    check_eq("rstmid_rvalid_n1", data_rvalid, 1'b0);
    advance();
    reset = 1'b0;
    sample();
    check_eq("rstmid_rvalid_n2", data_rvalid, 1'b0);
    advance();
    idle(1);

    // read-data hold after a fetch
    preload(32'h0000_0200, 32'hDEAD_BEEF);
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    step();
    inst_req = 1'b0;
    sample();
    check_eq("hold_first", inst_rdata, 32'hDEAD_BEEF);
    advance();
    for (int k = 0; k < 5; k++) begin
      sample();
      check_eq("hold_rvalid", inst_rvalid, 1'b0);
`ifdef SRAM_ARB_RDATA_HOLD_EN
      check_eq("hold_rdata", inst_rdata, 32'hDEAD_BEEF);
`endif
      advance();
    end

    // random traffic; each requester holds its request until granted
    inst_req = 1'b0; data_req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      sample();
      advance();
      if (m_ig || !inst_req) begin
        inst_req  = ($urandom_range(0, 3) != 0);
        inst_addr = rnd_addr();
      end
      if (m_dg || !data_req) begin
        data_req   = ($urandom_range(0, 3) != 0);
        data_addr  = rnd_addr();
        data_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        data_wdata = $urandom;
      end
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
